// File: rtl/seg7_bin_display.sv
// seg7_bin_display
// Multi-digit 7-segment display controller. A binary value captured on an
// accepted load is converted to BCD one bit per clock (shift-add-3), then
// latched into a display register that drives NUM_DIGITS active-low segment
// buses with optional leading-zero blanking, overflow dashes and blinking.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   load      start a conversion of value (only accepted when idle)
//   value     unsigned binary value, captured on the accepted load
//   blank_lz  1 = blank leading zero digits (digit 0 is always shown)
//   blink_en  1 = whole display blinks with a BLINK_DIV-cycle half period
//   busy      conversion in progress
//   done      one-cycle pulse when new digits reach the display
//   overflow  last converted value did not fit in NUM_DIGITS digits
//   segs      digit i at [7i+6:7i], bit6 = a ... bit0 = g, 0 = lit
module seg7_bin_display #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [WIDTH-1:0]        value,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segs
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] bcd;
  logic             scr_ovf;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] disp_digits;
  logic             disp_valid;

  logic [BLK_W-1:0] blink_cnt;
  logic             phase_on;

  // Adjusted scratch BCD for this shift step: every digit >= 5 gets +3.
  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM and display register. The top bit of the adjusted BCD is
  // what falls off the end on each shift; a 1 there means the value needs
  // more digits than we have.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bcd         <= '0;
      scr_ovf     <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      disp_digits <= '0;
      disp_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= value;
            bcd     <= '0;
            scr_ovf <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= {bcd_adj[BCD_W-2:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          if (bcd_adj[BCD_W-1])
            scr_ovf <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= UPDATE;
        end
        UPDATE: begin
          disp_digits <= bcd;
          disp_valid  <= 1'b1;
          overflow    <= scr_ovf;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink timebase: free-runs only while blinking, otherwise parked in the
  // visible phase so the display reappears as soon as blinking stops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  function automatic logic [6:0] encode_digit(input logic [3:0] d);
    case (d)
      4'd0:    encode_digit = 7'b0000001;
      4'd1:    encode_digit = 7'b1001111;
      4'd2:    encode_digit = 7'b0010010;
      4'd3:    encode_digit = 7'b0000110;
      4'd4:    encode_digit = 7'b1001100;
      4'd5:    encode_digit = 7'b0100100;
      4'd6:    encode_digit = 7'b0100000;
      4'd7:    encode_digit = 7'b0001111;
      4'd8:    encode_digit = 7'b0000000;
      4'd9:    encode_digit = 7'b0000100;
      default: encode_digit = 7'b1111111;
    endcase
  endfunction

  // Segment pattern. During UPDATE the finished scratch result is used
  // directly so segs changes on the same edge that raises done, while the
  // display register still holds the old result for every other cycle.
  logic [SEG_W-1:0] segs_next;
  logic [BCD_W-1:0] src_digits;
  logic             src_valid;
  logic             src_ovf;
  logic             seen_nz;
  logic [3:0]       digit;
  logic [6:0]       code;

  always_comb begin
    src_digits = (state == UPDATE) ? bcd : disp_digits;
    src_valid  = (state == UPDATE) || disp_valid;
    src_ovf    = (state == UPDATE) ? scr_ovf : overflow;
    segs_next  = '1;
    seen_nz    = 1'b0;
    digit      = '0;
    code       = 7'b1111111;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = src_digits[4*i +: 4];
      if (digit != 4'd0)
        seen_nz = 1'b1;
      if (!src_valid)
        code = 7'b1111111;
      else if (src_ovf)
        code = 7'b1111110;
      else if (blank_lz && !seen_nz && (i != 0))
        code = 7'b1111111;
      else
        code = encode_digit(digit);
      segs_next[7*i +: 7] = code;
    end
    if (blink_en && !phase_on)
      segs_next = '1;
  end

  // Output register for the segment buses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      segs <= '1;
    else
      segs <= segs_next;
  end

endmodule

// File: tb/tb_seg7_bin_display.sv
// tb_seg7_bin_display
// Directed bench for seg7_bin_display. Instance a uses WIDTH=10,
// NUM_DIGITS=4, BLINK_DIV=4; instance b uses NUM_DIGITS=2 for overflow cases.
module tb_seg7_bin_display;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic clk;
  logic reset_n;

  logic        load_a, blank_lz_a, blink_en_a, busy_a, done_a, overflow_a;
  logic [9:0]  value_a;
  logic [27:0] segs_a;

  logic        load_b, blank_lz_b, blink_en_b, busy_b, done_b, overflow_b;
  logic [9:0]  value_b;
  logic [13:0] segs_b;

  int total;
  int bad;

  seg7_bin_display #(.WIDTH(10), .NUM_DIGITS(4), .BLINK_DIV(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load_a), .value(value_a),
    .blank_lz(blank_lz_a), .blink_en(blink_en_a), .busy(busy_a),
    .done(done_a), .overflow(overflow_a), .segs(segs_a)
  );

  seg7_bin_display #(.WIDTH(10), .NUM_DIGITS(2), .BLINK_DIV(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load_b), .value(value_b),
    .blank_lz(blank_lz_b), .blink_en(blink_en_b), .busy(busy_b),
    .done(done_b), .overflow(overflow_b), .segs(segs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one cycle on the selected instance; returns just after
  // the accepting edge.
  task automatic applyStimulus(input bit sel, input logic [9:0] val);
    if (sel) begin
      value_b = val;
      load_b  = 1'b1;
    end else begin
      value_a = val;
      load_a  = 1'b1;
    end
    tick();
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Full conversion: busy must last exactly 11 cycles, then done pulses
  // together with the new segment pattern, then done drops.
  task automatic runConversion(input string tag, input bit sel,
                               input logic [9:0] val, input logic [31:0] exp_segs);
    int n;
    applyStimulus(sel, val);
    n = 0;
    while ((sel ? busy_b : busy_a) && n < 60) begin
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, n, 11);
    checkOutput({tag, "_done"}, sel ? done_b : done_a, 1);
    checkOutput({tag, "_segs"}, sel ? {18'd0, segs_b} : {4'd0, segs_a}, exp_segs);
    tick();
    checkOutput({tag, "_done_drop"}, sel ? done_b : done_a, 0);
  endtask

  initial begin
    int dones;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    load_a = 0; value_a = '0; blank_lz_a = 0; blink_en_a = 0;
    load_b = 0; value_b = '0; blank_lz_b = 0; blink_en_b = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_segs_a", {4'd0, segs_a}, 32'h0fffffff);
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_done_a", done_a, 0);
    checkOutput("rst_ovf_a", overflow_a, 0);
    checkOutput("rst_segs_b", {18'd0, segs_b}, 32'h00003fff);

    // 987 without and with leading-zero blanking
    runConversion("v987", 1'b0, 10'd987, {4'd0, S0, S9, S8, S7});
    checkOutput("v987_ovf", overflow_a, 0);
    blank_lz_a = 1'b1;
    tick();
    checkOutput("v987_lz", {4'd0, segs_a}, {4'd0, SB, S9, S8, S7});
    runConversion("v0_lz", 1'b0, 10'd0, {4'd0, SB, SB, SB, S0});

    // Overflow on the two-digit instance, then a value that fits
    runConversion("v100", 1'b1, 10'd100, {18'd0, SD, SD});
    checkOutput("v100_ovf", overflow_b, 1);
    runConversion("v99", 1'b1, 10'd99, {18'd0, S9, S9});
    checkOutput("v99_ovf", overflow_b, 0);

    // Second load three cycles into a conversion is dropped
    blank_lz_a = 1'b0;
    applyStimulus(1'b0, 10'd123);
    tick();
    tick();
    value_a = 10'd456;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a) dones++;
      tick();
    end
    checkOutput("ign_dones", dones, 1);
    checkOutput("ign_segs", {4'd0, segs_a}, {4'd0, S0, S1, S2, S3});
    checkOutput("ign_busy", busy_a, 0);

    // Async reset mid-conversion
    applyStimulus(1'b0, 10'd987);
    tick();
    tick();
    checkOutput("mid_busy_pre", busy_a, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy_a, 0);
    checkOutput("mid_rst_segs", {4'd0, segs_a}, 32'h0fffffff);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_segs", {4'd0, segs_a}, 32'h0fffffff);

    // Blinking with BLINK_DIV=4: 4 cycles shown, 4 blank, ...
    blank_lz_a = 1'b1;
    runConversion("v5", 1'b0, 10'd5, {4'd0, SB, SB, SB, S5});
    blink_en_a = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      checkOutput($sformatf("blink_%0d", j), {4'd0, segs_a},
                  (((j / 4) % 2) == 0) ? {4'd0, SB, SB, SB, S5} : 32'h0fffffff);
    end
    tick();
    checkOutput("blink_off", {4'd0, segs_a}, 32'h0fffffff);
    blink_en_a = 1'b0;
    tick();
    checkOutput("blink_restore", {4'd0, segs_a}, {4'd0, SB, SB, SB, S5});
    tick();
    checkOutput("blink_hold", {4'd0, segs_a}, {4'd0, SB, SB, SB, S5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
